// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants, state encoding and frame payload type for the 7-segment scan controller.
package seg_scan_ctrl_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIG_W      = $clog2(NUM_DIGITS);
  localparam int unsigned SEG_W      = 8;
  localparam logic [SEG_W-1:0] SEG_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
  localparam logic [6:0] HEX7_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] nib;
    logic [NUM_DIGITS-1:0]      dp;
    logic [NUM_DIGITS-1:0]      blank;
  } disp_frame_t;

endpackage

// File: rtl/seg_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment glyph lookup.
module hex_to_seg7
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg7_c_o
);

  assign seg7_c_o = HEX7_TBL[nibble_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit 7-segment scan controller with frame-coherent shadow data.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [31:0]           data_in,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic [NUM_DIGITS-1:0] blank_in,
  input  logic                  load,
  output logic                  load_ack,
  output logic [DIG_W-1:0]      digit_sel,
  output logic [SEG_W-1:0]      seg_n,
  output logic                  frame_done
);

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END  = DIV_W'(BLANK_CYC);
  localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

  scan_state_e      state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [DIG_W-1:0] digit_q, digit_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             ack_q, ack_d;
  logic             fdone_q, fdone_d;
  logic             pend_q, pend_d;
  disp_frame_t      pend_frame_q, pend_frame_d;
  disp_frame_t      shadow_q, shadow_d;

  disp_frame_t      in_frame;
  logic             scanning;
  logic             tick;
  logic             wrap;
  logic [6:0]       glyph_c;

  assign in_frame = '{nib: data_in, dp: dp_in, blank: blank_in};
  assign scanning = (state_q == ST_SCAN) && en;
  assign tick     = scanning && (presc_q == PRESC_LAST);
  assign wrap     = tick && (digit_q == DIG_LAST);

  hex_to_seg7 u_hex (
    .nibble_i (shadow_q.nib[digit_q]),
    .seg7_c_o (glyph_c)
  );

  // Next-state, scan counters, segment pattern and load handshake
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    digit_d      = digit_q;
    seg_d        = SEG_OFF;
    ack_d        = 1'b0;
    fdone_d      = 1'b0;
    pend_d       = pend_q;
    pend_frame_d = pend_frame_q;
    shadow_d     = shadow_q;

    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        digit_d = '0;
        if (en) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (!en) begin
          state_d = ST_IDLE;
          presc_d = '0;
          digit_d = '0;
        end else begin
          if (tick) begin
            presc_d = '0;
            digit_d = digit_q + DIG_W'(1);
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
          fdone_d = wrap;
          if ((presc_q >= BLANK_END) && !shadow_q.blank[digit_q])
            seg_d = {~shadow_q.dp[digit_q], glyph_c};
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // While scanning, shadow only moves on the frame wrap; a load on that cycle bypasses pending
    if (scanning) begin
      if (wrap && (load || pend_q)) begin
        shadow_d = load ? in_frame : pend_frame_q;
        pend_d   = 1'b0;
        ack_d    = 1'b1;
      end else if (load) begin
        pend_frame_d = in_frame;
        pend_d       = 1'b1;
      end
    end else begin
      if (pend_q) begin
        shadow_d = pend_frame_q;
        pend_d   = 1'b0;
        ack_d    = 1'b1;
      end
      if (load) begin
        pend_frame_d = in_frame;
        pend_d       = 1'b1;
      end
    end
  end

  // Shadow resets with every digit blanked so nothing lights before the first load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      digit_q      <= '0;
      seg_q        <= SEG_OFF;
      ack_q        <= 1'b0;
      fdone_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_frame_q <= '0;
      shadow_q     <= '{nib: '0, dp: '0, blank: '1};
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      seg_q        <= seg_d;
      ack_q        <= ack_d;
      fdone_q      <= fdone_d;
      pend_q       <= pend_d;
      pend_frame_q <= pend_frame_d;
      shadow_q     <= shadow_d;
    end
  end

  assign load_ack   = ack_q;
  assign digit_sel  = digit_q;
  assign seg_n      = seg_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a cycle-count reference model (SCAN_DIV=4, BLANK_CYC=1).
module tb_seg_scan_ctrl;

  localparam int DIV  = 4;
  localparam int BLK  = 1;
  localparam int FRM  = DIV * 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  blank_in = '0;
  logic        load = 1'b0;
  logic        load_ack;
  logic [2:0]  digit_sel;
  logic [7:0]  seg_n;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int fd_cnt = 0;

  // model: m_k counts scan cycles since SCAN was entered; position = m_k mod frame
  int        m_k;
  bit        m_scan;
  bit [3:0]  m_nib [8];
  bit [7:0]  m_dp, m_blank;
  bit        m_pend;
  bit [31:0] p_data;
  bit [7:0]  p_dp, p_blank;
  bit [7:0]  e_seg;
  bit [2:0]  e_dig;
  bit        e_ack, e_fd;

  seg_scan_ctrl #(.DIV_W(16), .SCAN_DIV(DIV), .BLANK_CYC(BLK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .load       (load),
    .load_ack   (load_ack),
    .digit_sel  (digit_sel),
    .seg_n      (seg_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic bit [6:0] hex7(input bit [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_shadow(input bit [31:0] d, input bit [7:0] dp, input bit [7:0] bl);
    for (int i = 0; i < 8; i++) m_nib[i] = d[4*i +: 4];
    m_dp = dp;
    m_blank = bl;
  endtask

  task automatic model_reset();
    m_k = 0; m_scan = 0; m_pend = 0;
    apply_shadow(32'h0, 8'h00, 8'hFF);
    e_seg = 8'hFF; e_dig = 0; e_ack = 0; e_fd = 0;
  endtask

  // One rising edge of the model, using the inputs present before that edge
  task automatic model_edge();
    bit scanning;
    int slot, ph;
    bit wrap;
    scanning = m_scan && en;
    slot = (m_k / DIV) % 8;
    ph = m_k % DIV;
    wrap = scanning && ((m_k % FRM) == FRM - 1);
    e_seg = 8'hFF;
    if (scanning && ph >= BLK && !m_blank[slot]) e_seg = {~m_dp[slot], hex7(m_nib[slot])};
    e_fd = wrap;
    e_ack = 0;
    if (scanning) begin
      if (wrap && (load || m_pend)) begin
        if (load) apply_shadow(data_in, dp_in, blank_in);
        else apply_shadow(p_data, p_dp, p_blank);
        m_pend = 0; e_ack = 1;
      end else if (load) begin
        p_data = data_in; p_dp = dp_in; p_blank = blank_in; m_pend = 1;
      end
    end else begin
      if (m_pend) begin
        apply_shadow(p_data, p_dp, p_blank);
        m_pend = 0; e_ack = 1;
      end
      if (load) begin
        p_data = data_in; p_dp = dp_in; p_blank = blank_in; m_pend = 1;
      end
    end
    m_k = scanning ? m_k + 1 : 0;
    m_scan = en;
    e_dig = 3'((m_k / DIV) % 8);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check("digit_sel", 8'(digit_sel), 8'(e_dig));
    check("seg_n", seg_n, e_seg);
    check("load_ack", 8'(load_ack), 8'(e_ack));
    check("frame_done", 8'(frame_done), 8'(e_fd));
    if (load_ack) ack_cnt++;
    if (frame_done) fd_cnt++;
    load = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_digit(input logic [2:0] d);
    int n = 0;
    while (digit_sel == d && n < 100) begin step(); n++; end
    while (digit_sel != d && n < 100) begin step(); n++; end
    check("wait_digit_timeout", 8'(n < 100), 8'd1);
  endtask

  task automatic wait_ack();
    int n = 0;
    while (!load_ack && n < 100) begin step(); n++; end
    check("wait_ack_timeout", 8'(n < 100), 8'd1);
  endtask

  task automatic do_load(input bit [31:0] d, input bit [7:0] dp, input bit [7:0] bl);
    data_in = d; dp_in = dp; blank_in = bl; load = 1'b1;
    step();
  endtask

  initial begin
    model_reset();
    steps(2);
    rst_n = 1'b1;
    check("rst_seg", seg_n, 8'hFF);
    check("rst_dig", 8'(digit_sel), 8'h00);
    check("rst_ack", 8'(load_ack), 8'h00);
    check("rst_fd", 8'(frame_done), 8'h00);
    steps(2);

    // IDLE load: ack two cycles after the load cycle
    do_load(32'h76543210, 8'h00, 8'h00);
    check("idle_ack_early", 8'(load_ack), 8'h00);
    step();
    check("idle_ack", 8'(load_ack), 8'h01);

    // scan order and slot-3 glyph
    en = 1'b1;
    wait_digit(3'd3);
    step();
    check("slot3_blank", seg_n, 8'hFF);
    step();
    check("slot3_glyph", seg_n, 8'hB0);
    fd_cnt = 0;
    steps(64);
    check("frame_done_count", 8'(fd_cnt), 8'd2);

    // frame-coherent load taken at digit 2
    wait_digit(3'd2);
    do_load(32'hFFFFFFFF, 8'h00, 8'h00);
    wait_ack();
    check("ack_at_digit0", 8'(digit_sel), 8'h00);
    step();
    check("d0_blank", seg_n, 8'hFF);
    step();
    check("d0_F", seg_n, 8'h8E);

    // two loads in one frame: last wins, single ack
    wait_digit(3'd1);
    ack_cnt = 0;
    do_load(32'h11111111, 8'h00, 8'h00);
    steps(4);
    do_load(32'h22222222, 8'h00, 8'h00);
    wait_ack();
    steps(2);
    check("last_wins_glyph", seg_n, 8'hA4);
    steps(40);
    check("single_ack", 8'(ack_cnt), 8'd1);

    // load coincident with wrap tick
    wait_digit(3'd7);
    steps(DIV - 1);
    do_load(32'h0000000A, 8'h00, 8'h00);
    check("coincident_ack", 8'(load_ack), 8'h01);
    steps(2);
    check("coincident_glyph", seg_n, 8'h88);

    // blank and decimal point
    do_load(32'h00000000, 8'h01, 8'h80);
    wait_ack();
    steps(2);
    check("dp_digit0", seg_n, 8'h40);
    steps(4);
    check("digit1_zero", seg_n, 8'hC0);
    steps(40);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 7) == 0) begin
        data_in = $urandom; dp_in = 8'($urandom); blank_in = 8'($urandom_range(0, 255) & 8'h55);
        load = 1'b1;
      end
      step();
    end

    // IDLE: dark next cycle, load acked after two cycles, then scan the new data
    en = 1'b1;
    steps(10);
    en = 1'b0;
    step();
    check("idle_dark", seg_n, 8'hFF);
    do_load(32'h89ABCDEF, 8'hFF, 8'h00);
    step();
    check("idle_ack2", 8'(load_ack), 8'h01);
    en = 1'b1;
    steps(40);

    // async reset mid-scan drops a pending load
    wait_digit(3'd3);
    do_load(32'h13579BDF, 8'h00, 8'h00);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_seg", seg_n, 8'hFF);
    check("async_rst_dig", 8'(digit_sel), 8'h00);
    check("async_rst_ack", 8'(load_ack), 8'h00);
    en = 1'b0;
    model_reset();
    steps(3);
    rst_n = 1'b1;
    ack_cnt = 0;
    steps(40);
    check("no_ack_after_reset", 8'(ack_cnt), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
